// File: rtl/iic_adc_scan.sv
// Round-robin I2C ADC poller: each PERIOD-cycle slot writes a channel-select byte,
// reads one conversion and keeps the last non-zero result per channel (capture latency 1).
module iic_adc_scan #(
  parameter int         PERIOD    = 12000,
  parameter int         WR_OFFSET = 500,
  parameter int         RD_OFFSET = 5500,
  parameter int         NUM_CH    = 4,
  parameter int         DATA_W    = 16,
  parameter logic [7:0] CFG_BASE  = 8'h84,
  localparam int        CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  output logic                     m_wr_req,
  output logic                     m_rd_req,
  output logic [7:0]               m_cfg_data,
  input  logic                     m_done,
  input  logic [DATA_W-1:0]        m_ad_voltage,
  output logic [NUM_CH*DATA_W-1:0] ad_voltage_valid,
  output logic [NUM_CH-1:0]        ch_update,
  output logic [7:0]               zero_cnt,
  output logic                     err_timeout,
  output logic [CH_W-1:0]          cur_ch
);

  localparam int CNT_W = $clog2(PERIOD);
  localparam logic [CNT_W-1:0] WR_AT   = CNT_W'(WR_OFFSET);
  localparam logic [CNT_W-1:0] RD_AT   = CNT_W'(RD_OFFSET);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(PERIOD - 1);
  localparam logic [CH_W-1:0]  CH_LAST = CH_W'(NUM_CH - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT_WR = 3'd1;
  localparam logic [2:0] S_WR_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_RD = 3'd3;
  localparam logic [2:0] S_RD_BUSY = 3'd4;
  localparam logic [2:0] S_HOLD    = 3'd5;

  logic [2:0]                 state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [CH_W-1:0]            cur_ch_q, cur_ch_d;
  logic [7:0]                 cfg_q, cfg_d;
  logic [NUM_CH*DATA_W-1:0]   ad_q, ad_d;
  logic [NUM_CH-1:0]          upd_q, upd_d;
  logic [7:0]                 zcnt_q, zcnt_d;
  logic [2:0]                 ch_sel;

  logic wrap;
  logic wr_busy;
  logic rd_busy;
  logic wr_tmo;
  logic rd_tmo;

  assign wrap    = (state_q != S_IDLE) && (cnt_q == LAST);
  assign wr_busy = (state_q == S_WR_BUSY);
  assign rd_busy = (state_q == S_RD_BUSY);
  // A done arriving on the deadline cycle still counts, so it masks the timeout.
  assign wr_tmo  = wr_busy && !m_done && ((cnt_q == RD_AT) || wrap);
  assign rd_tmo  = rd_busy && !m_done && wrap;

  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    cur_ch_d = cur_ch_q;
    if (state_q != S_IDLE) begin
      cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
    end
    case (state_q)
      S_IDLE:    if (enable) state_d = S_WAIT_WR;
      S_WAIT_WR: if (cnt_q == WR_AT) state_d = S_WR_BUSY;
      S_WR_BUSY: begin
        if (m_done) state_d = S_WAIT_RD;
        else if (cnt_q == RD_AT) state_d = S_HOLD;
      end
      S_WAIT_RD: if (cnt_q == RD_AT) state_d = S_RD_BUSY;
      S_RD_BUSY: if (m_done) state_d = S_HOLD;
      S_HOLD:    state_d = S_HOLD;
      default:   state_d = S_IDLE;
    endcase
    // Slot boundary overrides whatever the slot was doing.
    if (wrap) begin
      cur_ch_d = (cur_ch_q == CH_LAST) ? '0 : cur_ch_q + CH_W'(1);
      state_d  = enable ? S_WAIT_WR : S_IDLE;
    end
  end

  // Config byte is loaded one edge early so it is already valid during the write pulse.
  always_comb begin
    ch_sel = 3'(cur_ch_d);
    cfg_d  = cfg_q;
    if ((state_d == S_WAIT_WR) && (cnt_d == WR_AT)) begin
      cfg_d = CFG_BASE | {1'b0, ch_sel, 4'b0000};
    end
  end

  always_comb begin
    ad_d   = ad_q;
    upd_d  = '0;
    zcnt_d = zcnt_q;
    if (rd_busy && m_done) begin
      if (m_ad_voltage != '0) begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (cur_ch_q == CH_W'(c)) begin
            ad_d[c*DATA_W +: DATA_W] = m_ad_voltage;
            upd_d[c]                 = 1'b1;
          end
        end
      end else if (zcnt_q != 8'hFF) begin
        zcnt_d = zcnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      cur_ch_q <= '0;
      cfg_q    <= '0;
      ad_q     <= '0;
      upd_q    <= '0;
      zcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cur_ch_q <= cur_ch_d;
      cfg_q    <= cfg_d;
      ad_q     <= ad_d;
      upd_q    <= upd_d;
      zcnt_q   <= zcnt_d;
    end
  end

  assign m_wr_req         = (state_q == S_WAIT_WR) && (cnt_q == WR_AT);
  assign m_rd_req         = (state_q == S_WAIT_RD) && (cnt_q == RD_AT);
  assign m_cfg_data       = cfg_q;
  assign ad_voltage_valid = ad_q;
  assign ch_update        = upd_q;
  assign zero_cnt         = zcnt_q;
  assign err_timeout      = wr_tmo | rd_tmo;
  assign cur_ch           = cur_ch_q;

endmodule

// File: tb/tb_iic_adc_scan.sv
// Bench for iic_adc_scan: open-loop master stimulus per slot, slot-level reference model
// feeding an event scoreboard, plus direct checks of register state at quiet points.
`timescale 1ns/1ps
module tb_iic_adc_scan;
  localparam int PERIOD = 100, WR_OFFSET = 5, RD_OFFSET = 50, NUM_CH = 4, DATA_W = 16;
  localparam int K_WR = 0, K_RD = 1, K_UPD = 2, K_ERR = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        m_done = 1'b0;
  logic [15:0] m_ad_voltage = '0;
  logic        m_wr_req, m_rd_req, err_timeout;
  logic [7:0]  m_cfg_data, zero_cnt;
  logic [63:0] ad_voltage_valid;
  logic [3:0]  ch_update;
  logic [1:0]  cur_ch;

  iic_adc_scan #(.PERIOD(PERIOD), .WR_OFFSET(WR_OFFSET), .RD_OFFSET(RD_OFFSET),
                 .NUM_CH(NUM_CH), .DATA_W(DATA_W), .CFG_BASE(8'h84)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .m_wr_req(m_wr_req), .m_rd_req(m_rd_req), .m_cfg_data(m_cfg_data),
    .m_done(m_done), .m_ad_voltage(m_ad_voltage),
    .ad_voltage_valid(ad_voltage_valid), .ch_update(ch_update),
    .zero_cnt(zero_cnt), .err_timeout(err_timeout), .cur_ch(cur_ch)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct { int cyc; int kind; logic [63:0] val; logic [7:0] aux; } ev_t;
  ev_t exp_q[$];

  typedef struct { int wr_dly; int rd_dly; logic [15:0] data; int x1; int x2; int en_drop; int rst_at; } plan_t;

  // Reference model state: next channel, result image, zero counter.
  int          m_ch = 0;
  logic [63:0] m_ad = '0;
  int          m_zc = 0;
  bit          dn [0:99];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic plan_t mk(input int wr, input int rd, input logic [15:0] data);
    plan_t p;
    p.wr_dly = wr; p.rd_dly = rd; p.data = data;
    p.x1 = -1; p.x2 = -1; p.en_drop = -1; p.rst_at = -1;
    return p;
  endfunction

  // Slot-level rules: write accepted by the first done in (WR_OFFSET, RD_OFFSET],
  // read accepted by the first done in (RD_OFFSET, PERIOD-1].
  function automatic void model_slot(input plan_t p, input int base);
    int lim = (p.rst_at >= 0) ? p.rst_at : 1000;
    int wa = -1;
    int ra = -1;
    logic [7:0] cfg = 8'h84 | 8'(m_ch << 4);
    if (WR_OFFSET <= lim) exp_q.push_back('{cyc: base + WR_OFFSET, kind: K_WR, val: 64'(m_ch), aux: cfg});
    for (int t = WR_OFFSET + 1; t <= RD_OFFSET; t++) if (dn[t] && wa < 0) wa = t;
    if (wa < 0) begin
      if (RD_OFFSET <= lim) exp_q.push_back('{cyc: base + RD_OFFSET, kind: K_ERR, val: 64'd0, aux: 8'd0});
    end else if (wa < RD_OFFSET) begin
      if (RD_OFFSET <= lim) exp_q.push_back('{cyc: base + RD_OFFSET, kind: K_RD, val: 64'd0, aux: 8'd0});
      for (int t = RD_OFFSET + 1; t < PERIOD; t++) if (dn[t] && ra < 0) ra = t;
      if (ra < 0) begin
        if (PERIOD - 1 <= lim) exp_q.push_back('{cyc: base + PERIOD - 1, kind: K_ERR, val: 64'd0, aux: 8'd0});
      end else if (p.data != 16'd0) begin
        m_ad[m_ch*16 +: 16] = p.data;
        exp_q.push_back('{cyc: base + ra + 1, kind: K_UPD, val: m_ad, aux: 8'(1 << m_ch)});
      end else if (m_zc < 255) begin
        m_zc++;
      end
    end
    m_ch = (m_ch + 1) % NUM_CH;
    if (p.rst_at >= 0) begin
      m_ch = 0; m_ad = '0; m_zc = 0;
    end
  endfunction

  // Called with one cycle left before the slot starts; returns after driving its last cycle.
  task automatic run_slot(input plan_t p);
    int base = cyc + 1;
    for (int t = 0; t < PERIOD; t++) dn[t] = 1'b0;
    if (p.wr_dly >= 0 && WR_OFFSET + p.wr_dly < PERIOD) dn[WR_OFFSET + p.wr_dly] = 1'b1;
    if (p.rd_dly >= 0 && RD_OFFSET + p.rd_dly < PERIOD) dn[RD_OFFSET + p.rd_dly] = 1'b1;
    if (p.x1 >= 0 && p.x1 < PERIOD) dn[p.x1] = 1'b1;
    if (p.x2 >= 0 && p.x2 < PERIOD) dn[p.x2] = 1'b1;
    if (p.rst_at >= 0) for (int t = p.rst_at; t < PERIOD; t++) dn[t] = 1'b0;
    model_slot(p, base);
    for (int t = 0; t < PERIOD; t++) begin
      @(posedge clk); #1;
      if (t == p.en_drop) enable = 1'b0;
      if (t == p.rst_at) begin
        rst = 1'b1;
        m_done = 1'b0;
        break;
      end
      m_done = dn[t];
      m_ad_voltage = dn[t] ? p.data : 16'($urandom);
    end
    m_done = 1'b0;
  endtask

  task automatic match(input int k, input logic [63:0] v, input logic [7:0] a);
    ev_t e;
    total++;
    if (exp_q.size() == 0 || exp_q[0].cyc > cyc) begin
      bad++;
      $display("FAIL unexpected_event: got kind=%0d at cycle %0d, required none", k, cyc);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != k || e.val !== v || e.aux !== a) begin
      bad++;
      $display("FAIL event_c%0d: got kind=%0d val=%0h aux=%0h, required kind=%0d val=%0h aux=%0h",
               cyc, k, v, a, e.kind, e.val, e.aux);
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        total++; bad++;
        $display("FAIL missing_event: kind=%0d required at cycle %0d, absent", exp_q[0].kind, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (m_wr_req)          match(K_WR, 64'(cur_ch), m_cfg_data);
      if (m_rd_req)          match(K_RD, 64'd0, 8'd0);
      if (ch_update != 4'd0) match(K_UPD, ad_voltage_valid, {4'd0, ch_update});
      if (err_timeout)       match(K_ERR, 64'd0, 8'd0);
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic chk_zero_state(input string tag);
    chk({tag, "_wr"},  64'(m_wr_req), 64'd0);
    chk({tag, "_rd"},  64'(m_rd_req), 64'd0);
    chk({tag, "_cfg"}, 64'(m_cfg_data), 64'd0);
    chk({tag, "_ad"},  ad_voltage_valid, 64'd0);
    chk({tag, "_upd"}, 64'(ch_update), 64'd0);
    chk({tag, "_zc"},  64'(zero_cnt), 64'd0);
    chk({tag, "_err"}, 64'(err_timeout), 64'd0);
    chk({tag, "_ch"},  64'(cur_ch), 64'd0);
  endtask

  initial begin : stim
    plan_t p;
    repeat (3) @(posedge clk);
    #1;
    chk_zero_state("reset");
    rst = 1'b0;
    enable = 1'b1;

    // First slot on ch0, then four consecutive slots with distinct data.
    run_slot(mk(3, 3, 16'h1234));
    chk("ad_first", ad_voltage_valid, 64'h0000_0000_0000_1234);
    run_slot(mk(3, 3, 16'h0022));
    run_slot(mk(3, 3, 16'h0033));
    run_slot(mk(3, 3, 16'h0044));
    run_slot(mk(3, 3, 16'h0011));
    chk("ad_4slots", ad_voltage_valid, 64'h0044_0033_0022_0011);

    // ch1 zero reading: slice kept, counted.
    run_slot(mk(3, 3, 16'h0000));
    chk("zero_slice", ad_voltage_valid, 64'h0044_0033_0022_0011);
    chk("zero_cnt_1", 64'(zero_cnt), 64'd1);

    // ch2 write timeout, ch3 read timeout, ch0 normal.
    run_slot(mk(-1, 3, 16'h0AAA));
    run_slot(mk(3, -1, 16'h0BBB));
    run_slot(mk(3, 3, 16'h0CCC));
    chk("after_tmo", ad_voltage_valid, 64'h0044_0033_0022_0CCC);

    // ch1: done in the request cycle ignored, real done at 9, stray done in WAIT_RD ignored.
    p = mk(0, 3, 16'h0D0D); p.x1 = 9; p.x2 = 30;
    run_slot(p);
    // ch2: write done exactly on the read deadline is accepted without error.
    run_slot(mk(RD_OFFSET - WR_OFFSET, 3, 16'h0E0E));
    run_slot(mk(3, 3, 16'h0F0F));
    chk("after_edge", ad_voltage_valid, 64'h0F0F_0033_0D0D_0CCC);

    for (int i = 0; i < 25; i++) begin
      p = mk(($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 46)),
             ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 52)),
             ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom));
      if ($urandom_range(0, 3) == 0) p.x1 = int'($urandom_range(0, 99));
      if ($urandom_range(0, 3) == 0) p.x2 = int'($urandom_range(0, 99));
      run_slot(p);
    end
    run_slot(mk(3, 3, 16'h5A5A));
    chk("rand_ad", ad_voltage_valid, m_ad);
    chk("rand_zc", 64'(zero_cnt), 64'(m_zc));

    for (int i = 0; i < 300; i++) run_slot(mk(3, 3, 16'h0000));
    chk("zero_cnt_sat", 64'(zero_cnt), 64'd255);

    // Enable dropped mid-slot: slot completes, then no activity while idle.
    p = mk(3, 3, 16'h0055); p.en_drop = 30;
    run_slot(p);
    repeat (250) begin @(posedge clk); #1; end
    chk("idle_cur_ch", 64'(cur_ch), 64'(m_ch));
    enable = 1'b1;
    run_slot(mk(3, 3, 16'h0066));
    chk("reenable_ad", ad_voltage_valid, m_ad);

    // Reset while the read is outstanding.
    p = mk(3, -1, 16'h0077); p.rst_at = 60;
    run_slot(p);
    @(posedge clk); #1;
    chk_zero_state("midrst");
    rst = 1'b0;
    run_slot(mk(3, 3, 16'hABCD));
    chk("post_rst_ad", ad_voltage_valid, 64'h0000_0000_0000_ABCD);

    repeat (5) begin @(posedge clk); #1; end
    while (exp_q.size() > 0) begin
      total++; bad++;
      $display("FAIL missing_event_end: kind=%0d required at cycle %0d, absent", exp_q[0].kind, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/iic_adc_scan.md
Name: iic_adc_scan

Overview:
- Periodic multi-channel I2C ADC poller; sits between system control and the I2C master.
- Each period slot serves one channel:
  - issues a config-write request carrying a channel-select byte;
  - issues a read request;
  - captures the returned conversion into a per-channel result register.
- Zero readings are rejected and counted; master responses that do not arrive in time are flagged.
- Channels are scanned round-robin, 0..NUM_CH-1.

Parameters:
- PERIOD, 12000, clock cycles per channel slot (min RD_OFFSET+2).
- WR_OFFSET, 500, slot cycle at which the write request is issued.
- RD_OFFSET, 5500, slot cycle at which the read request is issued (> WR_OFFSET).
- NUM_CH, 4, number of ADC channels (1..8).
- DATA_W, 16, conversion result width.
- CFG_BASE, 8'h84, config byte base; channel index is ORed into bits [6:4].

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- enable  in  1  scan enable, sampled at slot start
- m_wr_req  out  1  one-cycle write-request pulse to I2C master
- m_rd_req  out  1  one-cycle read-request pulse to I2C master
- m_cfg_data  out  8  config byte; stable from the write pulse until the next write pulse
- m_done  in  1  one-cycle completion pulse from the master (write or read)
- m_ad_voltage  in  DATA_W  read data; valid in the m_done cycle of a read
- ad_voltage_valid  out  NUM_CH*DATA_W  last non-zero result per channel; ch0 in LSBs
- ch_update  out  NUM_CH  one-cycle pulse when that channel's result is written
- zero_cnt  out  8  saturating count of rejected zero readings
- err_timeout  out  1  one-cycle pulse on write or read timeout
- cur_ch  out  clog2(NUM_CH) (min 1)  channel of the current slot

Behaviour:
- Reset (rst=1 at a clk edge) values:
  - slot counter 0, cur_ch 0, FSM IDLE;
  - all outputs 0, including ad_voltage_valid and zero_cnt;
  - m_cfg_data = 0.
  - Reset mid-operation aborts any pending transaction; no partial capture.
- Slot counter:
  - counts 0..PERIOD-1 then wraps to 0 while FSM ≠ IDLE;
  - held at 0 in IDLE.
- FSM states: IDLE, WAIT_WR, WR_BUSY, WAIT_RD, RD_BUSY, HOLD.
- IDLE: if enable=1, go to WAIT_WR next cycle with counter 0.
- WAIT_WR: at counter==WR_OFFSET:
  - pulse m_wr_req for 1 cycle;
  - load m_cfg_data = CFG_BASE | (cur_ch<<4);
  - go to WR_BUSY.
- WR_BUSY:
  - m_done → WAIT_RD.
  - If counter reaches RD_OFFSET without m_done: pulse err_timeout, skip the read, go to HOLD.
- WAIT_RD: at counter==RD_OFFSET, pulse m_rd_req for 1 cycle and go to RD_BUSY.
- RD_BUSY, on m_done:
  - m_ad_voltage≠0: write the cur_ch slice of ad_voltage_valid and pulse ch_update[cur_ch], both in the cycle after m_done (latency 1).
  - m_ad_voltage==0: slice unchanged, no ch_update, zero_cnt+1 (saturates at 255).
  - Go to HOLD.
  - If counter reaches PERIOD-1 without m_done: pulse err_timeout, go to HOLD.
- HOLD: wait for the counter wrap.
- At wrap (counter==PERIOD-1) from any non-IDLE state:
  - cur_ch advances, wrapping NUM_CH-1 → 0;
  - if enable=1, go to WAIT_WR, else IDLE (cur_ch kept).
  - A transaction still pending at wrap is abandoned with err_timeout.
- m_done handling:
  - ignored outside WR_BUSY/RD_BUSY;
  - ignored in the same cycle as the request pulse;
  - accepted from the following cycle.
- Simultaneous m_done and timeout cycle: m_done wins; no error.
- enable drop mid-slot: the slot completes normally, then IDLE.
- NUM_CH=1: cur_ch stays 0.

Test Plan:
- Params PERIOD=100, WR_OFFSET=5, RD_OFFSET=50, NUM_CH=4. Enable; master answers m_done 3 cycles after each req with data 16'h1234 → m_wr_req at slot cycle 5; m_cfg_data=8'h84 for ch0; m_rd_req at cycle 50; ch_update[0] 1 cycle after read done; ad_voltage_valid[15:0]=16'h1234.
- Four consecutive slots with data 16'h0011, 16'h0022, 16'h0033, 16'h0044 → m_cfg_data 8'h84, 8'h94, 8'hA4, 8'hB4; each slice holds its value; cur_ch returns to 0 on the fifth slot.
- Ch1 returns 16'h0000 after a prior 16'h0022 → slice stays 16'h0022, no ch_update, zero_cnt=1. Force 300 zero reads → zero_cnt holds at 255.
- No m_done after write → err_timeout pulse at slot cycle 50, no m_rd_req that slot, next slot proceeds normally. No m_done after read → err_timeout at cycle 99.
- m_done in the same cycle as m_wr_req, and stray m_done in WAIT_RD → both ignored. m_done exactly at cycle 50 in WR_BUSY → accepted, no error.
- rst asserted in RD_BUSY → all outputs 0 next cycle, cur_ch 0. Enable deasserted at cycle 30 → slot completes, then IDLE with no further requests.
